// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, state encoding and pre-decode record for the instruction fetch unit.
package inst_fetch_unit_pkg;

   localparam logic [5:0]  OPC_BEQ  = 6'h04;
   localparam logic [5:0]  OPC_J    = 6'h02;
   localparam logic [5:0]  OPC_JAL  = 6'h03;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2
   } fetch_state_t;

   // Pre-decode fields handed back to the next-PC logic
   typedef struct packed {
      logic        branch;
      logic        jump;
      logic [31:0] imm32;
      logic [25:0] imm26;
   } predecode_t;

   // Counter width for the REQ timeout; never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/inst_fetch_unit_predecode.sv
// Combinational pre-decode of an instruction word: branch/jump class and immediates.
module inst_predecode
   import inst_fetch_unit_pkg::*;
(
   input  logic [31:0] inst,
   output logic        branch,
   output logic        jump,
   output logic [31:0] imm32,
   output logic [25:0] imm26
);

   logic [5:0] opc;

   // Opcode classification and immediate extraction
   always_comb begin
      opc    = inst[31:26];
      branch = (opc == OPC_BEQ);
      jump   = (opc == OPC_J) || (opc == OPC_JAL);
      // Byte offset: sign-extended word offset shifted left by two
      imm32  = {{14{inst[15]}}, inst[15:0], 2'b00};
      imm26  = inst[25:0];
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetches the word at pc over a req/ack handshake with timeout,
// holds it (plus registered pre-decode) until the datapath consumes it, then fetches again.
module inst_fetch_unit #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] NOP_WORD       = inst_fetch_unit_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        exec_ready,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        pc_advance,
   output logic        branch,
   output logic        jump,
   output logic [31:0] imm32,
   output logic [25:0] imm26,
   output logic        fetch_err
);

   import inst_fetch_unit_pkg::*;

   localparam int          TW   = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   fetch_state_t  state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   inst_q, inst_d;
   logic          err_q, err_d;
   logic          start_fetch;
   predecode_t    dec_q, dec_d;

   // Decode the word about to be captured so the decode registers load alongside inst
   inst_predecode u_predecode (
      .inst   (inst_d),
      .branch (dec_d.branch),
      .jump   (dec_d.jump),
      .imm32  (dec_d.imm32),
      .imm26  (dec_d.imm26)
   );

   // Next-state logic: request/timeout handling and capture selection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      inst_d      = inst_q;
      err_d       = err_q;
      start_fetch = 1'b0;
      case (state_q)
         ST_IDLE:  start_fetch = 1'b1;
         ST_REQ: begin
            if (mem_ack) begin
               // Ack beats an expiring counter
               inst_d  = mem_rdata;
               state_d = ST_VALID;
            end else if (cnt_q == TMAX) begin
               inst_d  = NOP_WORD;
               err_d   = 1'b1;
               state_d = ST_VALID;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         ST_VALID: start_fetch = exec_ready;
         default:  state_d = ST_IDLE;
      endcase
      // Entering REQ: latch the address; a misaligned pc never raises mem_req
      if (start_fetch) begin
         addr_d = pc;
         cnt_d  = '0;
         if (pc[1:0] != 2'b00) begin
            inst_d  = NOP_WORD;
            err_d   = 1'b1;
            state_d = ST_VALID;
         end else begin
            state_d = ST_REQ;
         end
      end
   end

   // State, counter and capture registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         inst_q  <= '0;
         err_q   <= 1'b0;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         dec_q   <= dec_d;
      end
   end

   // Output mapping
   always_comb begin
      mem_req    = (state_q == ST_REQ);
      mem_addr   = addr_q;
      inst_valid = (state_q == ST_VALID);
      pc_advance = (state_q == ST_VALID) & exec_ready;
      inst       = inst_q;
      branch     = dec_q.branch;
      jump       = dec_q.jump;
      imm32      = dec_q.imm32;
      imm26      = dec_q.imm26;
      fetch_err  = err_q;
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit (TIMEOUT_CYCLES=16, NOP_WORD=0).
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        exec_ready;
   logic [31:0] inst;
   logic        inst_valid;
   logic        pc_advance;
   logic        branch;
   logic        jump;
   logic [31:0] imm32;
   logic [25:0] imm26;
   logic        fetch_err;

   int n_pass  = 0;
   int n_total = 0;

   inst_fetch_unit #(.TIMEOUT_CYCLES(16), .NOP_WORD(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .exec_ready (exec_ready),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc_advance (pc_advance),
      .branch     (branch),
      .jump       (jump),
      .imm32      (imm32),
      .imm26      (imm26),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   // One clock, then settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0; exec_ready = 1'b0;
      tick(); tick();
      n_total++;
      if ({mem_req, inst_valid, pc_advance, fetch_err, branch, jump} !== 6'b0)
         $display("FAIL reset_flags got %b want 000000", {mem_req, inst_valid, pc_advance, fetch_err, branch, jump});
      else n_pass++;
      n_total++;
      if ({inst, mem_addr, imm32, imm26} !== 122'b0)
         $display("FAIL reset_words got inst=%h addr=%h imm32=%h imm26=%h want 0", inst, mem_addr, imm32, imm26);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_first_fetch();
      tick();
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0)
         $display("FAIL ff_req got req=%b addr=%h want 1 00000000", mem_req, mem_addr);
      else n_pass++;
      tick(); tick();
      mem_ack = 1'b1; mem_rdata = 32'h1000_0003;
      #1;
      n_total++;
      if (inst_valid !== 1'b0) $display("FAIL ff_not_yet got %b want 0", inst_valid);
      else n_pass++;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      n_total++;
      if (inst_valid !== 1'b1 || mem_req !== 1'b0 || inst !== 32'h1000_0003)
         $display("FAIL ff_valid got v=%b req=%b inst=%h want 1 0 10000003", inst_valid, mem_req, inst);
      else n_pass++;
      n_total++;
      if (branch !== 1'b1 || jump !== 1'b0 || imm32 !== 32'h0000_000C || fetch_err !== 1'b0)
         $display("FAIL ff_decode got br=%b j=%b imm32=%h err=%b want 1 0 0000000c 0", branch, jump, imm32, fetch_err);
      else n_pass++;
   endtask

   task automatic test_hold();
      int stable_bad = 0;
      exec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (inst !== 32'h1000_0003 || imm32 !== 32'h0000_000C || branch !== 1'b1 ||
             inst_valid !== 1'b1 || pc_advance !== 1'b0) stable_bad++;
      end
      n_total++;
      if (stable_bad != 0) $display("FAIL hold_stable got %0d bad cycles want 0", stable_bad);
      else n_pass++;
      pc = 32'h0000_0004; exec_ready = 1'b1;
      #1;
      n_total++;
      if (pc_advance !== 1'b1) $display("FAIL hold_advance got %b want 1", pc_advance);
      else n_pass++;
      tick();
      exec_ready = 1'b0;
      n_total++;
      if (mem_req !== 1'b1 || inst_valid !== 1'b0 || pc_advance !== 1'b0 || mem_addr !== 32'h4)
         $display("FAIL hold_next_req got req=%b v=%b adv=%b addr=%h want 1 0 0 00000004",
                  mem_req, inst_valid, pc_advance, mem_addr);
      else n_pass++;
   endtask

   task automatic test_decode();
      mem_ack = 1'b1; mem_rdata = 32'h0800_0040;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if (jump !== 1'b1 || branch !== 1'b0 || imm26 !== 26'h000_0040 || imm32 !== 32'h0000_0100)
         $display("FAIL dec_j got j=%b br=%b imm26=%h imm32=%h want 1 0 0000040 00000100", jump, branch, imm26, imm32);
      else n_pass++;
      pc = 32'h0000_0008; exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
      n_total++;
      if (mem_addr !== 32'h8 || mem_req !== 1'b1)
         $display("FAIL dec_req2 got addr=%h req=%b want 00000008 1", mem_addr, mem_req);
      else n_pass++;
      mem_ack = 1'b1; mem_rdata = 32'h1000_FFFF;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if (imm32 !== 32'hFFFF_FFFC || branch !== 1'b1 || jump !== 1'b0 || imm26 !== 26'h000_FFFF)
         $display("FAIL dec_neg got imm32=%h br=%b j=%b imm26=%h want fffffffc 1 0 000ffff", imm32, branch, jump, imm26);
      else n_pass++;
      pc = 32'h0000_000C; exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int req_bad = 0;
      // exec_ready while in REQ must have no effect
      exec_ready = 1'b1;
      #1;
      n_total++;
      if (pc_advance !== 1'b0) $display("FAIL to_adv_in_req got %b want 0", pc_advance);
      else n_pass++;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i == 3) exec_ready = 1'b0;
         if (mem_req !== 1'b1 || inst_valid !== 1'b0) req_bad++;
      end
      n_total++;
      if (req_bad != 0) $display("FAIL to_held got %0d bad cycles want 0", req_bad);
      else n_pass++;
      tick();
      n_total++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0 || fetch_err !== 1'b1 || branch !== 1'b0)
         $display("FAIL to_abort got req=%b v=%b inst=%h err=%b br=%b want 0 1 00000000 1 0",
                  mem_req, inst_valid, inst, fetch_err, branch);
      else n_pass++;
      mem_ack = 1'b1; mem_rdata = 32'h1000_0003;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if (inst !== 32'h0 || inst_valid !== 1'b1 || mem_req !== 1'b0)
         $display("FAIL to_late_ack got inst=%h v=%b req=%b want 00000000 1 0", inst, inst_valid, mem_req);
      else n_pass++;
      pc = 32'h0000_0010; exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h0C00_0005;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if (inst !== 32'h0C00_0005 || jump !== 1'b1 || fetch_err !== 1'b1 || imm26 !== 26'h000_0005)
         $display("FAIL to_recover got inst=%h j=%b err=%b imm26=%h want 0c000005 1 1 0000005",
                  inst, jump, fetch_err, imm26);
      else n_pass++;
   endtask

   task automatic test_ack_at_timeout();
      reset = 1'b1; tick(); reset = 1'b0;
      pc = 32'h0000_0040;
      tick();
      for (int i = 0; i < 15; i++) tick();
      n_total++;
      if (mem_req !== 1'b1) $display("FAIL edge_still_req got %b want 1", mem_req);
      else n_pass++;
      mem_ack = 1'b1; mem_rdata = 32'h1000_0001;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if (inst !== 32'h1000_0001 || fetch_err !== 1'b0 || imm32 !== 32'h0000_0004 || mem_addr !== 32'h40)
         $display("FAIL edge_ack_wins got inst=%h err=%b imm32=%h addr=%h want 10000001 0 00000004 00000040",
                  inst, fetch_err, imm32, mem_addr);
      else n_pass++;
   endtask

   task automatic test_misaligned();
      pc = 32'h0000_0006; exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
      n_total++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0 || fetch_err !== 1'b1 || branch !== 1'b0)
         $display("FAIL mis_nop got req=%b v=%b inst=%h err=%b br=%b want 0 1 00000000 1 0",
                  mem_req, inst_valid, inst, fetch_err, branch);
      else n_pass++;
      tick();
      n_total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h6)
         $display("FAIL mis_no_req got req=%b addr=%h want 0 00000006", mem_req, mem_addr);
      else n_pass++;
   endtask

   task automatic test_reset_midflight();
      pc = 32'h0000_0020; exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
      n_total++;
      if (mem_req !== 1'b1) $display("FAIL rst_pre_req got %b want 1", mem_req);
      else n_pass++;
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0800_0001;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if ({mem_req, inst_valid, pc_advance, fetch_err, branch, jump} !== 6'b0 ||
          {inst, mem_addr, imm32, imm26} !== 122'b0)
         $display("FAIL rst_mid_req got req=%b v=%b err=%b inst=%h addr=%h want all 0",
                  mem_req, inst_valid, fetch_err, inst, mem_addr);
      else n_pass++;
      reset = 1'b0; pc = 32'h0000_0024;
      tick();
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h24)
         $display("FAIL rst_restart got req=%b addr=%h want 1 00000024", mem_req, mem_addr);
      else n_pass++;
      mem_ack = 1'b1; mem_rdata = 32'h1000_0003;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if (inst_valid !== 1'b1 || inst !== 32'h1000_0003 || branch !== 1'b1)
         $display("FAIL rst_zero_wait got v=%b inst=%h br=%b want 1 10000003 1", inst_valid, inst, branch);
      else n_pass++;
      reset = 1'b1; exec_ready = 1'b1;
      tick();
      #1;
      n_total++;
      if ({mem_req, inst_valid, pc_advance, fetch_err, branch, jump} !== 6'b0 ||
          {inst, mem_addr, imm32, imm26} !== 122'b0)
         $display("FAIL rst_mid_valid got req=%b v=%b adv=%b inst=%h want all 0",
                  mem_req, inst_valid, pc_advance, inst);
      else n_pass++;
      reset = 1'b0; exec_ready = 1'b0; pc = 32'h0000_0030;
      tick();
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h30 || inst_valid !== 1'b0)
         $display("FAIL rst_restart2 got req=%b addr=%h v=%b want 1 00000030 0", mem_req, mem_addr, inst_valid);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_hold();
      test_decode();
      test_timeout();
      test_ack_at_timeout();
      test_misaligned();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
